design_switch_ctrl: RTL and testbench

- Sequences design-slot changes on the multi-project chip top and feeds the slot multiplexer.
- Synchronizes and debounces the raw design-select pins.
- Rejects unpopulated slots.
- On each switch: blanks outputs, holds the outgoing design in reset, moves the mux select, then holds the incoming design in reset for a fixed window before release.

---
 rtl/design_switch_ctrl.sv | 131 +++++++++++++
 tb/tb_design_switch_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/design_switch_ctrl.sv
// Design-slot switch sequencer: debounces sel_req, then blanks, moves sel_cur and holds the new design in reset.
// Registered outputs; with SEL_LOCK_EN defined, lock freezes the selection while idle.
module design_switch_ctrl #(
  parameter int SEL_W         = 6,
  parameter int STABLE_CYCLES = 4,
  parameter int BLANK_CYCLES  = 2,
  parameter int RST_CYCLES    = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [SEL_W-1:0]      sel_req,
  input  logic [2**SEL_W-1:0]   populated,
  input  logic                  lock,
  output logic [SEL_W-1:0]      sel_cur,
  output logic                  des_rst,
  output logic                  out_blank,
  output logic                  busy,
  output logic                  sel_err,
  output logic [7:0]            switch_cnt
);

  typedef enum logic [1:0] {IDLE, BLANK, RESET} state_t;

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] BLANK_INIT = 8'(BLANK_CYCLES - 1);
  localparam logic [7:0] RST_INIT   = 8'(RST_CYCLES - 1);

  state_t           state, state_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic [SEL_W-1:0] sync1, sync2, cand, target, target_nxt, sel_cur_nxt;
  logic [7:0]       stab_cnt, switch_cnt_nxt;
  logic             sel_err_nxt, first_done, first_done_nxt;
  logic             stable, hold;

  assign stable = (stab_cnt == STABLE_MAX);

`ifdef SEL_LOCK_EN
  assign hold = lock;
`else
  logic unused_lock;
  assign unused_lock = lock;
  assign hold = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1      <= '0;
      sync2      <= '0;
      cand       <= '0;
      stab_cnt   <= '0;
      state      <= RESET;
      cnt        <= RST_INIT;
      sel_cur    <= '0;
      target     <= '0;
      sel_err    <= 1'b0;
      switch_cnt <= '0;
      first_done <= 1'b0;
      des_rst    <= 1'b1;
      out_blank  <= 1'b1;
      busy       <= 1'b1;
    end else begin
      sync1 <= sel_req;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand     <= sync2;
        stab_cnt <= '0;
      end else if (stab_cnt != STABLE_MAX) begin
        stab_cnt <= stab_cnt + 8'd1;
      end
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sel_cur    <= sel_cur_nxt;
      target     <= target_nxt;
      sel_err    <= sel_err_nxt;
      switch_cnt <= switch_cnt_nxt;
      first_done <= first_done_nxt;
      // Outputs follow the next state so they are true flops aligned with it.
      des_rst    <= (state_nxt != IDLE);
      out_blank  <= (state_nxt != IDLE);
      busy       <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    sel_cur_nxt    = sel_cur;
    target_nxt     = target;
    sel_err_nxt    = sel_err;
    switch_cnt_nxt = switch_cnt;
    first_done_nxt = first_done;
    case (state)
      IDLE: begin
        if (stable && !hold && (cand != sel_cur)) begin
          if (populated[cand]) begin
            target_nxt = cand;
            cnt_nxt    = BLANK_INIT;
            state_nxt  = BLANK;
          end else begin
            sel_err_nxt = 1'b1;
          end
        end
      end
      BLANK: begin
        if (cnt == 8'd0) begin
          sel_cur_nxt = target;
          cnt_nxt     = RST_INIT;
          state_nxt   = RESET;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      RESET: begin
        if (cnt == 8'd0) begin
          state_nxt   = IDLE;
          sel_err_nxt = 1'b0;
          // The power-on release is not a switch.
          if (first_done) switch_cnt_nxt = switch_cnt + 8'd1;
          first_done_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: begin
        state_nxt = RESET;
        cnt_nxt   = RST_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_design_switch_ctrl.sv
// Bench for design_switch_ctrl: table of multi-cycle vectors plus hand-written reset, blank-window and lock sequences.
module tb_design_switch_ctrl;

  localparam logic [63:0] ALL = {64{1'b1}};
  localparam logic [63:0] NO4 = ~(64'd1 << 4);

  logic        clock;
  logic        reset;
  logic [5:0]  sel_req;
  logic [63:0] populated;
  logic        lock;
  logic [5:0]  sel_cur;
  logic        des_rst, out_blank, busy, sel_err;
  logic [7:0]  switch_cnt;

  int tests = 0;
  int fails = 0;

  design_switch_ctrl dut (
    .clock(clock), .reset(reset), .sel_req(sel_req), .populated(populated), .lock(lock),
    .sel_cur(sel_cur), .des_rst(des_rst), .out_blank(out_blank), .busy(busy),
    .sel_err(sel_err), .switch_cnt(switch_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    int          gap;
    logic [5:0]  req;
    logic [63:0] pop;
    logic [5:0]  e_sel;
    logic        e_rst;
    logic        e_blank;
    logic        e_busy;
    logic        e_err;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vt[14];

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [5:0] s, input logic r, input logic b,
                         input logic bz, input logic e, input logic [7:0] c);
    chk({tag, ".sel_cur"}, 64'(sel_cur), 64'(s));
    chk({tag, ".des_rst"}, 64'(des_rst), 64'(r));
    chk({tag, ".out_blank"}, 64'(out_blank), 64'(b));
    chk({tag, ".busy"}, 64'(busy), 64'(bz));
    chk({tag, ".sel_err"}, 64'(sel_err), 64'(e));
    chk({tag, ".switch_cnt"}, 64'(switch_cnt), 64'(c));
  endtask

  initial begin
    int first_hi;
    int hi_cnt;
    // gap = negedges waited after driving; checks land after edge k+gap-1 (cumulative while inputs hold).
    vt[0]  = '{7,  6'd5, ALL, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vt[1]  = '{1,  6'd5, ALL, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    vt[2]  = '{1,  6'd5, ALL, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    vt[3]  = '{1,  6'd5, ALL, 6'd5, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    vt[4]  = '{7,  6'd5, ALL, 6'd5, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    vt[5]  = '{1,  6'd5, ALL, 6'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    vt[6]  = '{3,  6'd3, ALL, 6'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    vt[7]  = '{6,  6'd5, ALL, 6'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    vt[8]  = '{6,  6'd5, ALL, 6'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    vt[9]  = '{7,  6'd4, NO4, 6'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    vt[10] = '{1,  6'd4, NO4, 6'd5, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    vt[11] = '{5,  6'd4, NO4, 6'd5, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    vt[12] = '{8,  6'd7, NO4, 6'd5, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1};
    vt[13] = '{10, 6'd7, NO4, 6'd7, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};

    reset = 1'b0; sel_req = '0; populated = ALL; lock = 1'b0;
    step(3);
    chk_all("reset", 6'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);

    reset = 1'b1;
    step(7);
    chk("release_hold.des_rst", 64'(des_rst), 64'd1);
    step(1);
    chk_all("release_done", 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    for (int i = 0; i < 14; i++) begin
      sel_req   = vt[i].req;
      populated = vt[i].pop;
      step(vt[i].gap);
      chk_all($sformatf("vec%0d", i), vt[i].e_sel, vt[i].e_rst, vt[i].e_blank,
              vt[i].e_busy, vt[i].e_err, vt[i].e_cnt);
    end

    // Blank window of a 7->5 switch: rises after edge k+7, high for exactly 10 cycles.
    sel_req = 6'd5; populated = ALL;
    first_hi = -1; hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (out_blank === 1'b1) begin
        hi_cnt++;
        if (first_hi < 0) first_hi = i;
      end
    end
    chk("blank_first_edge", 64'(first_hi), 64'd7);
    chk("blank_len", 64'(hi_cnt), 64'd10);
    chk_all("sw7to5", 6'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);

    // Reset during BLANK of a 5->10 switch aborts it.
    sel_req = 6'd10;
    step(8);
    chk("mid_blank.busy", 64'(busy), 64'd1);
    chk("mid_blank.sel_cur", 64'(sel_cur), 64'd5);
    reset = 1'b0; sel_req = 6'd0;
    step(1);
    chk_all("abort", 6'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    reset = 1'b1;
    step(8);
    chk_all("abort_release", 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Lock while requesting 0->2.
    lock = 1'b1; sel_req = 6'd2;
    step(12);
`ifdef SEL_LOCK_EN
    chk("lock_hold.busy", 64'(busy), 64'd0);
    chk("lock_hold.sel_cur", 64'(sel_cur), 64'd0);
    lock = 1'b0;
    step(1);
    chk("unlock_blank.busy", 64'(busy), 64'd1);
    chk("unlock_blank.sel_cur", 64'(sel_cur), 64'd0);
    step(2);
    chk("unlock_sel.sel_cur", 64'(sel_cur), 64'd2);
`else
    chk("lock_ignored.busy", 64'(busy), 64'd1);
    chk("lock_ignored.sel_cur", 64'(sel_cur), 64'd2);
    lock = 1'b0;
    step(3);
    chk("lock_ignored2.sel_cur", 64'(sel_cur), 64'd2);
`endif
    step(12);
    chk_all("lock_end", 6'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
